// File: rtl/flexsoc_rst_pkg.sv
// -----------------------------------------------------------------------------
// flexsoc_rst_pkg
// Shared types for the flexsoc reset sequencer:
//   state_e : sequencer FSM states
//   cause_e : encoding of the reported last reset cause
//   max3    : helper used to size the shared down-counter
// -----------------------------------------------------------------------------
package flexsoc_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_LOCK = 2'd1,
    CAUSE_SYS  = 2'd2
  } cause_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/flexsoc_sync.sv
// -----------------------------------------------------------------------------
// flexsoc_sync
// Multi-bit, multi-stage flip-flop synchronizer. Each bit is synchronized
// independently, so use it only for quasi-static levels (PLL locks, SWD/UART
// control lines), never for multi-bit values that must be coherent.
// Ports:
//   hclk   in  1      destination clock
//   RESET  in  1      synchronous, active-high reset
//   i_d    in  WIDTH  asynchronous input levels
//   o_q    out WIDTH  synchronized levels, DEPTH cycles later
// -----------------------------------------------------------------------------
module flexsoc_sync #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             hclk,
  input  logic             RESET,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_sync;

  // NOTE: the chain is reset (not left to power up as X) so that a lock
  // can never appear asserted before it has really crossed the synchronizer.
  always_ff @(posedge hclk) begin
    if (RESET) begin
      r_sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what builds a real shift chain.
      r_sync[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/flexsoc_reset_seq.sv
// -----------------------------------------------------------------------------
// flexsoc_reset_seq
// Reset sequencer for the flexsoc FPGA top. Waits for every PLL to lock,
// stretches reset for HOLD_CYC cycles, then releases NUM_DOM domains in order
// (domain 0 = debug/PORESET first), STAGE_CYC cycles apart. A rising
// SYSRESETREQ in RUN re-resets every domain except domain 0. Loss of any lock
// outside WAIT_LOCK forces a full reset. All outputs are registered.
//
// Optional build macro: RSTSEQ_LOCK_FILTER_EN
//   defined   : lock loss must persist FILTER_CYC consecutive cycles to act
//   undefined : lock loss acts on the first low cycle of the synced lock
//
// Ports:
//   hclk          in  1         system clock
//   RESET         in  1         synchronous, active-high reset
//   pll_locked    in  NUM_LOCK  PLL lock levels, asynchronous to hclk
//   sysreset_req  in  1         core SYSRESETREQ level, hclk domain
//   rst_n         out NUM_DOM   per-domain active-low resets
//   all_released  out 1         every rst_n bit is 1
//   reset_cause   out 2         0=POR, 1=LOCK_LOSS, 2=SYSRESET
//   busy          out 1         sequencer is not in RUN
// -----------------------------------------------------------------------------
module flexsoc_reset_seq
  import flexsoc_rst_pkg::*;
#(
  parameter int NUM_DOM     = 3,
  parameter int NUM_LOCK    = 2,
  parameter int HOLD_CYC    = 16,
  parameter int STAGE_CYC   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_CYC  = 8
) (
  input  logic                hclk,
  input  logic                RESET,
  input  logic [NUM_LOCK-1:0] pll_locked,
  input  logic                sysreset_req,
  output logic [NUM_DOM-1:0]  rst_n,
  output logic                all_released,
  output logic [1:0]          reset_cause,
  output logic                busy
);

  localparam int CNT_W = $clog2(max3(HOLD_CYC, STAGE_CYC, FILTER_CYC) + 1);
  localparam int STG_W = $clog2(NUM_DOM);

  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAGE_LD = CNT_W'(STAGE_CYC - 1);
  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_DOM - 1);

  state_e             r_state;
  cause_e             r_cause;
  logic [CNT_W-1:0]   r_cnt;
  logic [STG_W-1:0]   r_stage;
  logic               r_partial;
  logic               r_sys_prev;
  logic [NUM_DOM-1:0] r_rst_n;
  logic               r_all_rel;
  logic               r_busy;

  logic [NUM_LOCK-1:0] w_lk_s;
  logic                w_lock_ok;
  logic                w_lock_loss;
  logic                w_sys_rise;
  logic [STG_W-1:0]    w_first_stg;
  logic [STG_W-1:0]    w_stage_nxt;

  flexsoc_sync #(
    .WIDTH (NUM_LOCK),
    .DEPTH (SYNC_STAGES)
  ) u_lock_sync (
    .hclk  (hclk),
    .RESET (RESET),
    .i_d   (pll_locked),
    .o_q   (w_lk_s)
  );

  assign w_lock_ok   = &w_lk_s;
  assign w_sys_rise  = sysreset_req & ~r_sys_prev;
  // A SYSRESET sequence skips domain 0, which was never re-asserted.
  assign w_first_stg = r_partial ? STG_W'(1) : STG_W'(0);
  assign w_stage_nxt = r_stage + STG_W'(1);

`ifdef RSTSEQ_LOCK_FILTER_EN
  // Counts consecutive low cycles of the synced lock; saturates at the
  // firing threshold. Held clear in WAIT_LOCK, where loss is not acted on.
  logic [CNT_W-1:0] r_filt;

  always_ff @(posedge hclk) begin
    if (RESET) begin
      r_filt <= '0;
    end else if (w_lock_ok || (r_state == WAIT_LOCK)) begin
      r_filt <= '0;
    end else if (r_filt != CNT_W'(FILTER_CYC - 1)) begin
      r_filt <= r_filt + CNT_W'(1);
    end
  end

  assign w_lock_loss = ~w_lock_ok && (r_filt == CNT_W'(FILTER_CYC - 1));
`else
  assign w_lock_loss = ~w_lock_ok;
`endif

  always_ff @(posedge hclk) begin
    if (RESET) begin
      r_state    <= WAIT_LOCK;
      r_cause    <= CAUSE_POR;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_partial  <= 1'b0;
      r_sys_prev <= 1'b0;
      r_rst_n    <= '0;
      r_all_rel  <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      // Tracked in every state so a level already high on return to RUN
      // is not mistaken for a new request.
      r_sys_prev <= sysreset_req;

      // Lock loss outranks everything, including a same-cycle SYSRESETREQ.
      if ((r_state != WAIT_LOCK) && w_lock_loss) begin
        r_state   <= WAIT_LOCK;
        r_cause   <= CAUSE_LOCK;
        r_cnt     <= '0;
        r_partial <= 1'b0;
        r_rst_n   <= '0;
        r_all_rel <= 1'b0;
        r_busy    <= 1'b1;
      end else begin
        case (r_state)
          WAIT_LOCK: begin
            r_rst_n <= '0;
            if (w_lock_ok) begin
              r_cnt   <= HOLD_LD;
              r_state <= STRETCH;
            end
          end

          STRETCH: begin
            if (r_cnt == '0) begin
              r_stage              <= w_first_stg;
              r_rst_n[w_first_stg] <= 1'b1;
              r_cnt                <= STAGE_LD;
              if (w_first_stg == LAST_STG) begin
                r_state   <= RUN;
                r_all_rel <= 1'b1;
                r_busy    <= 1'b0;
              end else begin
                r_state <= RELEASE;
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end

          RELEASE: begin
            if (r_cnt == '0) begin
              r_stage              <= w_stage_nxt;
              r_rst_n[w_stage_nxt] <= 1'b1;
              r_cnt                <= STAGE_LD;
              if (w_stage_nxt == LAST_STG) begin
                r_state   <= RUN;
                r_all_rel <= 1'b1;
                r_busy    <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end

          RUN: begin
            if (w_sys_rise) begin
              r_rst_n   <= NUM_DOM'(1);
              r_cause   <= CAUSE_SYS;
              r_cnt     <= HOLD_LD;
              r_partial <= 1'b1;
              r_all_rel <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= STRETCH;
            end
          end

          default: r_state <= WAIT_LOCK;
        endcase
      end
    end
  end

  assign rst_n        = r_rst_n;
  assign all_released = r_all_rel;
  assign reset_cause  = r_cause;
  assign busy         = r_busy;

endmodule

// File: tb/tb_flexsoc_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_flexsoc_reset_seq
// Self-checking bench for flexsoc_reset_seq. Stimulus predicts, from the
// sequencer's timing rules, every future change of the output tuple
// {rst_n, all_released, reset_cause, busy} together with the cycle it must
// appear on, and queues it. A monitor compares each observed change against
// the head of the queue; an observed change with nothing queued is an error.
// Honours RSTSEQ_LOCK_FILTER_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_flexsoc_reset_seq;

  localparam int ND    = 3;
  localparam int NL    = 2;
  localparam int HOLD  = 16;
  localparam int STAGE = 4;
  localparam int SYNC  = 2;
  localparam int FILT  = 8;
`ifdef RSTSEQ_LOCK_FILTER_EN
  localparam int F = FILT;
`else
  localparam int F = 1;
`endif
  localparam logic [1:0] C_POR  = 2'd0;
  localparam logic [1:0] C_LOCK = 2'd1;
  localparam logic [1:0] C_SYS  = 2'd2;

  logic          hclk = 1'b0;
  logic          RESET;
  logic [NL-1:0] pll_locked;
  logic          sysreset_req;
  logic [ND-1:0] rst_n;
  logic          all_released;
  logic [1:0]    reset_cause;
  logic          busy;

  always #5 hclk = ~hclk;

  flexsoc_reset_seq #(
    .NUM_DOM     (ND),
    .NUM_LOCK    (NL),
    .HOLD_CYC    (HOLD),
    .STAGE_CYC   (STAGE),
    .SYNC_STAGES (SYNC),
    .FILTER_CYC  (FILT)
  ) dut (
    .hclk         (hclk),
    .RESET        (RESET),
    .pll_locked   (pll_locked),
    .sysreset_req (sysreset_req),
    .rst_n        (rst_n),
    .all_released (all_released),
    .reset_cause  (reset_cause),
    .busy         (busy)
  );

  typedef struct {
    int            cyc;
    logic [ND-1:0] rst;
    logic          allr;
    logic [1:0]    cause;
    logic          busy;
  } exp_t;

  exp_t       sb[$];
  exp_t       last_popped;
  exp_t       mon_e;
  logic [1:0] m_cause;
  int         cyc    = 0;
  int         n_chk  = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic [ND+3:0] prev_v;
  logic [ND+3:0] cur_v;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  function automatic bit same_tuple(input exp_t a, input exp_t b);
    return (a.rst === b.rst) && (a.allr === b.allr) &&
           (a.cause === b.cause) && (a.busy === b.busy);
  endfunction

  // Queue an output change; a prediction equal to the tuple already in
  // force is not a visible change and is dropped.
  function automatic void expect_at(input int c, input logic [ND-1:0] r, input logic a,
                                    input logic [1:0] ca, input logic b);
    exp_t e;
    exp_t t;
    e.cyc = c; e.rst = r; e.allr = a; e.cause = ca; e.busy = b;
    if (sb.size() != 0) t = sb[$];
    else                t = last_popped;
    if (!same_tuple(e, t)) sb.push_back(e);
    m_cause = ca;
  endfunction

  // A reset event overrides every prediction at or after its own cycle.
  function automatic void cancel_from(input int c);
    while (sb.size() != 0 && sb[$].cyc >= c) void'(sb.pop_back());
  endfunction

  // Domains first..ND-1 come out STAGE cycles apart starting at t0.
  function automatic void predict_release(input int t0, input int first);
    logic [ND-1:0] r;
    r = '0;
    if (first > 0) r[0] = 1'b1;
    for (int d = first; d < ND; d++) begin
      r[d] = 1'b1;
      expect_at(t0 + STAGE * (d - first), r, (d == ND - 1), m_cause, (d != ND - 1));
    end
  endfunction

  // SYSRESETREQ rising, driven right after edge k, in RUN.
  function automatic void sys_predict(input int k);
    expect_at(k + 1, ND'(1), 1'b0, C_SYS, 1'b1);
    predict_release(k + 1 + HOLD, 1);
  endfunction

  always @(negedge hclk) begin
    if (mon_en) begin
      cur_v = {rst_n, all_released, reset_cause, busy};
      if (cur_v !== prev_v) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_change: got %b at cycle %0d, no change predicted", cur_v, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("event_cycle", cyc, mon_e.cyc);
          check("event_value", cur_v, {mon_e.rst, mon_e.allr, mon_e.cause, mon_e.busy});
          last_popped = mon_e;
        end
        prev_v = cur_v;
      end
    end
  end

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      step(1);
      n++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d predicted changes still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Drop lock bit b for dur cycles, optionally with a SYSRESETREQ pulse timed
  // to reach the sequencer on the same edge as the lock loss.
  task automatic do_loss(input int b, input int dur, input bit with_sys);
    int k;
    int eff;
    k   = cyc;
    eff = k + SYNC + F;
    pll_locked[b] = 1'b0;
    if (dur >= F) begin
      cancel_from(eff);
      expect_at(eff, '0, 1'b0, C_LOCK, 1'b1);
    end
    for (int s = 0; s < dur; s++) begin
      if (with_sys) sysreset_req = (cyc == eff - 1);
      step(1);
    end
    sysreset_req  = 1'b0;
    pll_locked[b] = 1'b1;
    if (dur >= F) predict_release(cyc + SYNC + HOLD + 1, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int j;
    int r0;
    int dur;
    RESET        = 1'b1;
    pll_locked   = '1;
    sysreset_req = 1'b0;
    m_cause      = C_POR;
    last_popped.cyc = 0; last_popped.rst = '0; last_popped.allr = 1'b0;
    last_popped.cause = C_POR; last_popped.busy = 1'b1;

    // Reset state.
    step(5);
    check("reset_rst_n", rst_n, 0);
    check("reset_all_released", all_released, 0);
    check("reset_cause", reset_cause, C_POR);
    check("reset_busy", busy, 1);
    prev_v = {{ND{1'b0}}, 1'b0, C_POR, 1'b1};
    mon_en = 1'b1;

    // Power-on sequence with both locks already present.
    RESET = 1'b0;
    predict_release(cyc + SYNC + HOLD + 1, 0);
    drain(100);
    step(10);

    // Single-cycle SYSRESETREQ pulse in RUN.
    step($urandom_range(1, 10));
    k = cyc;
    sysreset_req = 1'b1;
    sys_predict(k);
    step(1);
    sysreset_req = 1'b0;
    drain(100);
    step(5);

    // Pulse, then raise again during the stretch and hold: no retrigger.
    step($urandom_range(1, 10));
    k = cyc;
    sysreset_req = 1'b1;
    sys_predict(k);
    step(1);
    sysreset_req = 1'b0;
    step(4);
    sysreset_req = 1'b1;
    drain(100);
    step(20);
    sysreset_req = 1'b0;
    step(5);

    // Staggered locks after a fresh reset.
    k = cyc;
    RESET      = 1'b1;
    pll_locked = NL'(1);
    cancel_from(k + 1);
    expect_at(k + 1, '0, 1'b0, C_POR, 1'b1);
    step(4);
    RESET = 1'b0;
    step($urandom_range(25, 35));
    pll_locked = '1;
    j  = cyc;
    r0 = j + SYNC + HOLD + 1;
    predict_release(r0, 0);

    // Lose pll_locked[1] once domain 0 is out, then restore it.
    step(r0 - cyc);
    do_loss(1, F + 2 + $urandom_range(0, 8), 1'b0);
    drain(200);
    step(10);

    // SYSRESETREQ rising on the same edge the lock loss is seen.
    do_loss($urandom_range(0, NL - 1), F + 3 + $urandom_range(0, 5), 1'b1);
    drain(200);
    step(10);

    // Randomized lock glitches from RUN.
    for (int i = 0; i < 6; i++) begin
`ifdef RSTSEQ_LOCK_FILTER_EN
      if (i == 0)      dur = F - 1;
      else if (i == 1) dur = F;
      else             dur = $urandom_range(1, F + 4);
`else
      dur = $urandom_range(1, 4);
`endif
      step($urandom_range(2, 10));
      do_loss($urandom_range(0, NL - 1), dur, 1'b0);
      drain(200);
      step(5);
    end

    step(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
